acc_zero_flag: RTL
==================

Name: acc_zero_flag

Overview:
- Handshaked accumulator: ACC <= ACC (op) D per accepted transaction.
- The zero flag of each new result is computed in constant time from the operands, not from the carry-propagated sum, and is registered together with the result.
- Consumer side of the sum-zero-detection scheme: the datapath that actually produces the sums whose zero-ness is predicted.
- Sits in front of loop/branch logic that needs "result == 0" without waiting on the adder's critical path.

Parameters:
width, 8, accumulator and operand word width (>=2)
cntWidth, 16, width of the saturating accepted-operation counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
InValid  input  1  operation request valid
InReady  output  1  block can accept an operation this cycle
Op  input  2  00 NOP, 01 LOAD, 10 ADD, 11 SUB
D  input  width  operand
CI  input  1  carry in (ADD/SUB only)
OutValid  output  1  Result/Z/CO valid
OutReady  input  1  downstream accepts result
Result  output  width  accumulator value after last accepted op
Z  output  1  Result == 0, computed by constant-time detection
CO  output  1  carry out of the last ADD/SUB
ZS  output  1  sticky zero flag
ClrSticky  input  1  clears ZS
Count  output  cntWidth  number of accepted ops, saturating

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Reset values: Result=0, Z=0, CO=0, OutValid=0, ZS=0, Count=0.
  - Z=0 at reset despite ACC=0; Z is meaningful only when OutValid=1.
  - rst_i wins over every concurrent event, including an accept in the same cycle.
- Handshake:
  - InReady = ~OutValid | OutReady (combinational; no dependency on InValid).
  - Accept = InValid & InReady.
  - On accept: ACC, Z and CO update next edge and OutValid=1.
  - If OutReady=1 and no accept: OutValid=0 next edge.
  - While OutValid & ~OutReady: Result, Z and CO are held stable and InReady=0.
- Latency: 1 cycle from accept to OutValid. Throughput: 1 op/cycle when OutReady is held high.
- Operation table (Result is the single ACC register):
  - NOP: ACC unchanged; detector inputs (ACC, 0, 0); CO=0.
  - LOAD: ACC <= D; detector inputs (D, 0, 0); CO=0.
  - ADD: ACC <= ACC + D + CI, modulo 2^width; detector inputs (ACC, D, CI); CO = bit width of the width+1 sum.
  - SUB: ACC <= ACC + ~D + CI; detector inputs (ACC, ~D, CI).
    - CI=1 gives a true subtract.
    - CO=1 means no borrow.
- Zero detection:
  - Exactly one detector instance, fed by the operand mux (OpA, OpB, OpCI) above.
  - Z must never be derived from the adder output.
  - Invariant: OutValid -> (Z == (Result == 0)).
- Sticky flag:
  - On accept with a next Z of 1: ZS <= 1.
  - ClrSticky without such a set: ZS <= 0.
  - Simultaneous set and clear: set wins, ZS=1.
  - ClrSticky acts independently of the handshake.
- Count: increments on every accept (NOP included); saturates at 2^cntWidth-1, no wrap.
- Wrap-around: ADD/SUB overflow wraps silently; signed overflow is not flagged.

Decomposition:
- Package acc_zero_flag_pkg holds:
  - typedef enum logic [1:0] op_e {OP_NOP, OP_LOAD, OP_ADD, OP_SUB};
  - localparam encodings for the operation table.
- Sub-module: the existing SumZeroDet library cell (width=width) is the constant-time zero detector, instantiated once.
- Adder: plain width+1 behavioural addition.
- Everything else lives in one module: operand mux, registers, handshake, counter.

Test Plan:
- Reset, LOAD 0x05, then SUB D=0x05 CI=1 -> Result=0x00, Z=1, CO=1, ZS=1, Count=2.
- LOAD 0x01, then ADD D=0xFF CI=0 -> Result=0x00, Z=1, CO=1 (wrap). Then ADD D=0x00 CI=1 -> Result=0x01, Z=0, CO=0.
- Backpressure: ADD accepted, then OutReady=0 for 3 cycles with InValid=1.
  - During the stall: InReady=0, and Result, Z, CO are stable for all 3 cycles.
  - The second op is accepted only in the cycle OutReady=1; its result appears 1 cycle later.
- Sticky precedence:
  - ZS=1, then ClrSticky=1 in the same cycle as accepted LOAD 0x00 -> ZS stays 1.
  - ClrSticky=1 with a non-zero op -> ZS=0.
- Reset mid-operation: accept ADD with rst_i=1 in the same cycle -> next cycle Result=0, OutValid=0, Count=0, InReady=1.
- Random: 10k random Op/D/CI with random OutReady, checked against a behavioural model.
  - Check the Z invariant on every OutValid cycle.
  - Check Count saturation with cntWidth=4.

Source files
------------

// File: rtl/acc_zero_flag_pkg.sv
// Shared operation encodings and helpers for the zero-flag accumulator.
package acc_zero_flag_pkg;

    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_LOAD = 2'b01;
    localparam logic [1:0] OPC_ADD  = 2'b10;
    localparam logic [1:0] OPC_SUB  = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP  = OPC_NOP,
        OP_LOAD = OPC_LOAD,
        OP_ADD  = OPC_ADD,
        OP_SUB  = OPC_SUB
    } op_e;

    function automatic logic is_arith(op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/acc_zero_flag_if.sv
// Request/result bus of the zero-flag accumulator; master drives ops, slave is the datapath.
interface acc_zero_flag_if #(
    parameter int width    = 8,
    parameter int cntWidth = 16
);
    logic                InValid;
    logic                InReady;
    logic [1:0]          Op;
    logic [width-1:0]    D;
    logic                CI;
    logic                OutValid;
    logic                OutReady;
    logic [width-1:0]    Result;
    logic                Z;
    logic                CO;
    logic                ZS;
    logic                ClrSticky;
    logic [cntWidth-1:0] Count;

    modport master (
        output InValid, Op, D, CI, OutReady, ClrSticky,
        input  InReady, OutValid, Result, Z, CO, ZS, Count
    );

    modport slave (
        input  InValid, Op, D, CI, OutReady, ClrSticky,
        output InReady, OutValid, Result, Z, CO, ZS, Count
    );
endinterface

// File: rtl/SumZeroDet.sv
// Constant-time detector for (a + b + ci) mod 2^width == 0, without forming the sum.
module SumZeroDet #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             ci_i,
    output logic             z_o
);
    logic [width-1:0] prop;
    logic [width-1:0] need;

    // A zero sum forces carry-in(i) == a^b at bit i, hence carry-out(i) == a|b.
    assign prop = a_i ^ b_i;
    assign need = {a_i[width-2:0] | b_i[width-2:0], ci_i};
    assign z_o  = &(~(prop ^ need));
endmodule

// File: rtl/acc_zero_flag.sv
// Handshaked accumulator with a predicted zero flag, sticky zero and saturating op counter.
module acc_zero_flag
    import acc_zero_flag_pkg::*;
#(
    parameter int width    = 8,
    parameter int cntWidth = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    acc_zero_flag_if.slave bus
);
    op_e                 op;
    logic                in_ready;
    logic                accept;
    logic [width-1:0]    op_a;
    logic [width-1:0]    op_b;
    logic                op_ci;
    logic [width:0]      sum;
    logic                det_z;

    logic [width-1:0]    acc_q, acc_d;
    logic                z_q, z_d;
    logic                co_q, co_d;
    logic                valid_q, valid_d;
    logic                zs_q, zs_d;
    logic [cntWidth-1:0] cnt_q, cnt_d;

    assign op       = op_e'(bus.Op);
    assign in_ready = ~valid_q | bus.OutReady;
    assign accept   = bus.InValid & in_ready;

    // NOP and LOAD route through the same adder/detector with zero addends.
    always_comb begin
        op_a  = acc_q;
        op_b  = '0;
        op_ci = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_LOAD: op_a = bus.D;
            OP_ADD: begin
                op_b  = bus.D;
                op_ci = bus.CI;
            end
            OP_SUB: begin
                op_b  = ~bus.D;
                op_ci = bus.CI;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, op_a} + {1'b0, op_b} + {{width{1'b0}}, op_ci};

    SumZeroDet #(
        .width(width)
    ) u_det (
        .a_i  (op_a),
        .b_i  (op_b),
        .ci_i (op_ci),
        .z_o  (det_z)
    );

    always_comb begin
        acc_d   = acc_q;
        z_d     = z_q;
        co_d    = co_q;
        valid_d = valid_q;
        zs_d    = zs_q;
        cnt_d   = cnt_q;
        if (accept) begin
            acc_d   = sum[width-1:0];
            z_d     = det_z;
            co_d    = is_arith(op) & sum[width];
            valid_d = 1'b1;
            if (~&cnt_q) begin
                cnt_d = cnt_q + cntWidth'(1);
            end
        end else if (bus.OutReady) begin
            valid_d = 1'b0;
        end
        // A zero result arriving in the same cycle as a clear keeps the flag set.
        if (accept && det_z) begin
            zs_d = 1'b1;
        end else if (bus.ClrSticky) begin
            zs_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            z_q     <= 1'b0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
            zs_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            z_q     <= z_d;
            co_q    <= co_d;
            valid_q <= valid_d;
            zs_q    <= zs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = valid_q;
    assign bus.Result   = acc_q;
    assign bus.Z        = z_q;
    assign bus.CO       = co_q;
    assign bus.ZS       = zs_q;
    assign bus.Count    = cnt_q;
endmodule
